// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back select and 32-entry register file with forwarding feedback.
// Define WB_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_ctrl,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] alu_addr,
    input  logic [ADDR_W-1:0] wn,
    input  logic              jal,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              wb_wen,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [31:0]       wb_count
);
    logic [DATA_W-1:0] regs [2**ADDR_W];

    always_comb begin
        wb_waddr = jal ? ADDR_W'(LINK_REG) : wn;
        wb_wdata = (!jal && wb_ctrl[0]) ? rd_data : alu_addr;
        wb_wen   = (jal || wb_ctrl[1]) && (wb_waddr != '0) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
            wb_count <= '0;
        end else if (wb_wen) begin
            regs[wb_waddr] <= wb_wdata;
            wb_count       <= wb_count + 32'd1;
        end
    end

`ifdef WB_BYPASS_EN
    // wb_wen already excludes index 0, so $0 still reads as zero
    assign rs_data = (rs_addr == '0) ? '0 : (wb_wen && rs_addr == wb_waddr) ? wb_wdata : regs[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : (wb_wen && rt_addr == wb_waddr) ? wb_wdata : regs[rt_addr];
`else
    assign rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vector bench for wb_regfile (default or WB_BYPASS_EN build).
module tb_wb_regfile;
    logic        clk = 0;
    logic        rst;
    logic [1:0]  wb_ctrl;
    logic [31:0] rd_data, alu_addr;
    logic [4:0]  wn, rs_addr, rt_addr;
    logic        jal;
    logic [31:0] rs_data, rt_data, wb_wdata, wb_count;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    int errors = 0;
    int checks = 0;

    wb_regfile dut (
        .clk(clk), .rst(rst), .wb_ctrl(wb_ctrl), .rd_data(rd_data), .alu_addr(alu_addr),
        .wn(wn), .jal(jal), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
        .rt_data(rt_data), .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        jal;
        logic [1:0]  ctrl;
        logic [4:0]  wn;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t v [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 0; jal = 0; wb_ctrl = 2'b00; wn = 0; rd_data = 0; alu_addr = 0;
    endtask

    initial begin
        //        rst jal ctrl   wn     rd            alu           rs     rt     wen waddr  wdata         e_rs          e_rt          cnt
        v[0] = '{1'b0, 1'b0, 2'b10, 5'd5,  32'h0000DEAD, 32'h00001234, 5'd5,  5'd0,  1'b1, 5'd5,  32'h00001234, 32'h00001234, 32'h0,        32'd1};
        v[1] = '{1'b0, 1'b0, 2'b11, 5'd7,  32'hCAFEF00D, 32'h00005555, 5'd5,  5'd7,  1'b1, 5'd7,  32'hCAFEF00D, 32'h00001234, 32'hCAFEF00D, 32'd2};
        v[2] = '{1'b0, 1'b1, 2'b00, 5'd3,  32'h00000001, 32'h00400008, 5'd31, 5'd3,  1'b1, 5'd31, 32'h00400008, 32'h00400008, 32'h0,        32'd3};
        v[3] = '{1'b0, 1'b0, 2'b10, 5'd0,  32'h00000002, 32'h0000FFFF, 5'd0,  5'd5,  1'b0, 5'd0,  32'h0000FFFF, 32'h0,        32'h00001234, 32'd3};
        v[4] = '{1'b1, 1'b0, 2'b10, 5'd9,  32'h00000003, 32'h0000FFFF, 5'd9,  5'd5,  1'b0, 5'd9,  32'h0000FFFF, 32'h0,        32'h0,        32'd0};
        v[5] = '{1'b0, 1'b1, 2'b10, 5'd4,  32'h00000077, 32'h00000008, 5'd31, 5'd4,  1'b1, 5'd31, 32'h00000008, 32'h00000008, 32'h0,        32'd1};
        v[6] = '{1'b0, 1'b0, 2'b00, 5'd6,  32'h00000099, 32'h00000ABC, 5'd6,  5'd31, 1'b0, 5'd6,  32'h00000ABC, 32'h0,        32'h00000008, 32'd1};
        v[7] = '{1'b0, 1'b0, 2'b01, 5'd6,  32'h00000099, 32'h00000ABC, 5'd6,  5'd31, 1'b0, 5'd6,  32'h00000099, 32'h0,        32'h00000008, 32'd1};
        v[8] = '{1'b0, 1'b0, 2'b11, 5'd31, 32'hAAAA5555, 32'h00000001, 5'd31, 5'd31, 1'b1, 5'd31, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'd2};
        v[9] = '{1'b1, 1'b1, 2'b00, 5'd0,  32'h0,        32'h00000010, 5'd31, 5'd7,  1'b0, 5'd31, 32'h00000010, 32'h0,        32'h0,        32'd0};

        idle(); rst = 1; rs_addr = 0; rt_addr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(31 - i);
            #1;
            chk("reset_rs", rs_data, 32'h0);
            chk("reset_rt", rt_data, 32'h0);
        end
        chk("reset_cnt", wb_count, 32'h0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst = v[i].rst; jal = v[i].jal; wb_ctrl = v[i].ctrl; wn = v[i].wn;
            rd_data = v[i].rd; alu_addr = v[i].alu;
            #1;
            chk($sformatf("v%0d_wen", i), 32'(wb_wen), 32'(v[i].e_wen));
            chk($sformatf("v%0d_waddr", i), 32'(wb_waddr), 32'(v[i].e_waddr));
            chk($sformatf("v%0d_wdata", i), wb_wdata, v[i].e_wdata);
            @(posedge clk);
            #1 idle(); rs_addr = v[i].rs; rt_addr = v[i].rt;
            #1;
            chk($sformatf("v%0d_rs", i), rs_data, v[i].e_rs);
            chk($sformatf("v%0d_rt", i), rt_data, v[i].e_rt);
            chk($sformatf("v%0d_cnt", i), wb_count, v[i].e_cnt);
        end

        // same-cycle read of a register being written, plus $0 read during a $0 write
        @(negedge clk);
        wb_ctrl = 2'b10; wn = 12; alu_addr = 32'h5;
        @(negedge clk);
        alu_addr = 32'hABCD; rs_addr = 12; rt_addr = 12;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_rs_same", rs_data, 32'hABCD);
        chk("byp_rt_same", rt_data, 32'hABCD);
`else
        chk("byp_rs_same", rs_data, 32'h5);
        chk("byp_rt_same", rt_data, 32'h5);
`endif
        @(posedge clk);
        #1 idle();
        #1;
        chk("byp_rs_next", rs_data, 32'hABCD);
        chk("byp_rt_next", rt_data, 32'hABCD);
        chk("byp_cnt", wb_count, 32'd2);
        @(negedge clk);
        wb_ctrl = 2'b10; wn = 0; alu_addr = 32'h1234; rs_addr = 0; rt_addr = 0;
        #1;
        chk("zero_rs", rs_data, 32'h0);
        chk("zero_rt", rt_data, 32'h0);
        @(posedge clk);
        #1 idle();
        #1;
        chk("zero_cnt", wb_count, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
